// File: rtl/ir_packet_tx_if.sv
// Packet request / IR drive bundle between the 10 Hz tick logic and ir_packet_tx.
// DONE exists only when IR_TX_DONE_PULSE_EN is defined.
interface ir_packet_tx_if;
    logic       SEND_PACKET;
    logic [3:0] COMMAND;
    logic       BUSY;
    logic       IR_LED;
`ifdef IR_TX_DONE_PULSE_EN
    logic       DONE;

    modport master (output SEND_PACKET, output COMMAND, input BUSY, input IR_LED, input DONE);
    modport slave  (input SEND_PACKET, input COMMAND, output BUSY, output IR_LED, output DONE);
`else
    modport master (output SEND_PACKET, output COMMAND, input BUSY, input IR_LED);
    modport slave  (input SEND_PACKET, input COMMAND, output BUSY, output IR_LED);
`endif
endinterface

// File: rtl/ir_packet_tx.sv
// Serialises one IR packet (start, car-select, four command bits) per SEND_PACKET tick.
// Optional macro IR_TX_DONE_PULSE_EN adds a one-cycle DONE pulse on the last packet cycle.
//
// state  | meaning
// IDLE   | waiting for SEND_PACKET
// START  | start burst
// SELECT | car-select burst
// RIGHT  | command bit [3] burst
// LEFT   | command bit [2] burst
// BACK   | command bit [1] burst
// FWD    | command bit [0] burst
// GAPn   | silent gap after the preceding burst; GAP5 returns to IDLE
module ir_packet_tx #(
    parameter int unsigned CARRIER_HALF_PERIOD   = 1389,
    parameter int unsigned START_BURST_SIZE      = 88,
    parameter int unsigned CAR_SELECT_BURST_SIZE = 22,
    parameter int unsigned GAP_SIZE              = 40,
    parameter int unsigned ASSERT_BURST_SIZE     = 44,
    parameter int unsigned DEASSERT_BURST_SIZE   = 22
) (
    input  logic          CLK,
    input  logic          RESET,
    ir_packet_tx_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, START, GAP0, SELECT, GAP1, RIGHT, GAP2,
        LEFT, GAP3, BACK, GAP4, FWD, GAP5
    } state_t;

    localparam logic [15:0] PHASE_LAST = 16'(2 * CARRIER_HALF_PERIOD - 1);
    localparam logic [15:0] PHASE_HIGH = 16'(CARRIER_HALF_PERIOD);
    localparam logic [15:0] SZ_START   = 16'(START_BURST_SIZE);
    localparam logic [15:0] SZ_SELECT  = 16'(CAR_SELECT_BURST_SIZE);
    localparam logic [15:0] SZ_GAP     = 16'(GAP_SIZE);
    localparam logic [15:0] SZ_ONE     = 16'(ASSERT_BURST_SIZE);
    localparam logic [15:0] SZ_ZERO    = 16'(DEASSERT_BURST_SIZE);

    state_t      state_q, state_d;
    logic [15:0] phase_q, phase_d;
    logic [15:0] period_q, period_d;
    logic [3:0]  cmd_q, cmd_d;
    logic        led_q, led_d;
    logic [15:0] seg_size;
    logic        seg_last;

    always_comb begin
        seg_size = SZ_GAP;
        case (state_q)
            START:   seg_size = SZ_START;
            SELECT:  seg_size = SZ_SELECT;
            RIGHT:   seg_size = cmd_q[3] ? SZ_ONE : SZ_ZERO;
            LEFT:    seg_size = cmd_q[2] ? SZ_ONE : SZ_ZERO;
            BACK:    seg_size = cmd_q[1] ? SZ_ONE : SZ_ZERO;
            FWD:     seg_size = cmd_q[0] ? SZ_ONE : SZ_ZERO;
            default: seg_size = SZ_GAP;
        endcase
    end

    assign seg_last = (phase_q == PHASE_LAST) && (period_q == seg_size - 16'd1);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q + 16'd1;
        period_d = period_q;
        cmd_d    = cmd_q;
        if (state_q == IDLE) begin
            phase_d  = 16'd0;
            period_d = 16'd0;
            if (bus.SEND_PACKET) begin
                state_d = START;
                cmd_d   = bus.COMMAND;
            end
        end else if (seg_last) begin
            state_d  = (state_q == GAP5) ? IDLE : state_t'(state_q + 4'd1);
            phase_d  = 16'd0;
            period_d = 16'd0;
        end else if (phase_q == PHASE_LAST) begin
            phase_d  = 16'd0;
            period_d = period_q + 16'd1;
        end
        // The LED register is loaded from the next state so it lines up with it.
        led_d = (state_d inside {START, SELECT, RIGHT, LEFT, BACK, FWD}) &&
                (phase_d < PHASE_HIGH);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            phase_q  <= 16'd0;
            period_q <= 16'd0;
            cmd_q    <= 4'd0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            cmd_q    <= cmd_d;
            led_q    <= led_d;
        end
    end

    assign bus.IR_LED = led_q;
    assign bus.BUSY   = (state_q != IDLE);

`ifdef IR_TX_DONE_PULSE_EN
    assign bus.DONE = (state_q == GAP5) && seg_last && !RESET;
`endif

endmodule

// File: tb/tb_ir_packet_tx.sv
// Directed + randomized bench for ir_packet_tx against a per-cycle waveform model
// built from the packet's segment list.
module tb_ir_packet_tx;
    localparam int HALF = 2;
    localparam int P    = 2 * HALF;
    localparam int S_START = 3, S_SEL = 2, S_GAP = 1, S_ONE = 2, S_ZERO = 1;

    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;
    bit   exp_q[$];

    ir_packet_tx_if bus ();

    ir_packet_tx #(
        .CARRIER_HALF_PERIOD(HALF), .START_BURST_SIZE(S_START),
        .CAR_SELECT_BURST_SIZE(S_SEL), .GAP_SIZE(S_GAP),
        .ASSERT_BURST_SIZE(S_ONE), .DEASSERT_BURST_SIZE(S_ZERO)
    ) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_done(input logic exp);
`ifdef IR_TX_DONE_PULSE_EN
        check("done", bus.DONE, exp);
`else
        if (exp === 1'bx) check("done_unused", 1'b0, 1'b1);
`endif
    endtask

    // Expected IR_LED for every cycle of a packet, from the segment list.
    task automatic build(input logic [3:0] cmd);
        int sizes[12];
        exp_q.delete();
        sizes = '{S_START, S_GAP, S_SEL, S_GAP,
                  cmd[3] ? S_ONE : S_ZERO, S_GAP, cmd[2] ? S_ONE : S_ZERO, S_GAP,
                  cmd[1] ? S_ONE : S_ZERO, S_GAP, cmd[0] ? S_ONE : S_ZERO, S_GAP};
        for (int s = 0; s < 12; s++)
            for (int c = 0; c < sizes[s] * P; c++)
                exp_q.push_back((s % 2 == 0) && ((c % P) < HALF));
    endtask

    // Called from an idle cycle: pulses SEND_PACKET, then checks every packet cycle.
    // rej_a/rej_b: cycles (relative to k) with an extra SEND_PACKET; chg: cycle of a
    // COMMAND change; abort: cycle at which RESET (with SEND_PACKET) is applied, 0 = none.
    task automatic run_packet(input logic [3:0] cmd, input int rej_a, input int rej_b,
                              input int chg, input int abort);
        int len;
        build(cmd);
        len = exp_q.size();
        bus.COMMAND     = cmd;
        bus.SEND_PACKET = 1'b1;
        step();
        bus.SEND_PACKET = 1'b0;
        for (int n = 1; n <= len; n++) begin
            check($sformatf("led[%0d]", n), bus.IR_LED, exp_q[n-1]);
            check($sformatf("busy[%0d]", n), bus.BUSY, 1'b1);
            check_done(n == len);
            if (n == abort) begin
                RESET = 1'b1;
                bus.SEND_PACKET = 1'b1;
                step();
                check("abort_led", bus.IR_LED, 1'b0);
                check("abort_busy", bus.BUSY, 1'b0);
                check_done(1'b0);
                RESET = 1'b0;
                bus.SEND_PACKET = 1'b0;
                for (int i = 0; i < 3 * P; i++) begin
                    step();
                    check("post_abort_busy", bus.BUSY, 1'b0);
                    check("post_abort_led", bus.IR_LED, 1'b0);
                    check_done(1'b0);
                end
                return;
            end
            if (n == rej_a || n == rej_b) bus.SEND_PACKET = 1'b1;
            if (n == chg) bus.COMMAND = ~cmd;
            step();
            bus.SEND_PACKET = 1'b0;
        end
        check("end_busy", bus.BUSY, 1'b0);
        check("end_led", bus.IR_LED, 1'b0);
        check_done(1'b0);
    endtask

    initial begin
        RESET = 1'b1;
        bus.SEND_PACKET = 1'b1;
        bus.COMMAND = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_led", bus.IR_LED, 1'b0);
            check("rst_busy", bus.BUSY, 1'b0);
            check_done(1'b0);
        end
        RESET = 1'b0;
        bus.SEND_PACKET = 1'b0;

        // Full packet with rejected requests at k+20 and k+68, then back-to-back at k+69.
        run_packet(4'b1010, 20, 68, 0, 0);
        // All ones, COMMAND forced to its complement (0) mid-packet.
        run_packet(4'b1111, 0, 0, 10, 0);
        run_packet(4'b0000, 1, 0, 1, 0);

        for (int r = 0; r < 6; r++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            build(c);
            run_packet(c, $urandom_range(1, exp_q.size()), $urandom_range(1, exp_q.size()),
                       $urandom_range(1, exp_q.size()), 0);
            for (int i = 0; i < $urandom_range(0, 3); i++) begin
                step();
                check("idle_busy", bus.BUSY, 1'b0);
            end
        end

        // Reset mid-packet, then a clean packet to confirm recovery.
        run_packet(4'b1010, 0, 0, 0, 30);
        run_packet(4'($urandom_range(0, 15)), 0, 0, 0, $urandom_range(1, 60));
        run_packet(4'b0110, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
